// File: rtl/memory_bank_if.sv
// rtl/memory_bank_if.sv - access bundle for memory_bank
// Write port, registered read port, clear request and status flags.
interface memory_bank_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
);
  logic                 write;
  logic [ADDRWIDTH-1:0] address_w;
  logic [DATAWIDTH-1:0] data_in;
  logic                 read;
  logic [ADDRWIDTH-1:0] address_r;
  logic                 clear;
  logic [DATAWIDTH-1:0] data_out;
  logic                 data_valid;
  logic                 busy;
  logic                 addr_err;

  modport master (
    output write, address_w, data_in, read, address_r, clear,
    input  data_out, data_valid, busy, addr_err
  );

  modport slave (
    input  write, address_w, data_in, read, address_r, clear,
    output data_out, data_valid, busy, addr_err
  );
endinterface

// File: rtl/memory_bank.sv
// rtl/memory_bank.sv - simple dual-port RAM with clear sequencer
// One write port, one registered read port, range checking, fill-on-clear.
module memory_bank #(
  parameter int                   DATAWIDTH      = 8,
  parameter int                   ADDRWIDTH      = 8,
  parameter int                   DEPTH          = 256,
  parameter logic [DATAWIDTH-1:0] INIT_VALUE     = '0,
  parameter int                   CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  memory_bank_if.slave bus
);

  localparam int                   IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRWIDTH:0]   DEPTH_L = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH-1:0] LAST    = ADDRWIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;

  logic                 idle;
  logic                 w_ok, r_ok;
  logic                 do_write, do_read, hit, bad_access;
  logic [IDXW-1:0]      w_idx, r_idx, c_idx;

  assign idle       = (state_q == IDLE);
  assign w_ok       = ({1'b0, bus.address_w} < DEPTH_L);
  assign r_ok       = ({1'b0, bus.address_r} < DEPTH_L);
  assign do_write   = idle && bus.write && w_ok;
  assign do_read    = idle && bus.read;
  // Same-cycle write to the address being read forwards the new data.
  assign hit        = do_write && (bus.address_w == bus.address_r);
  assign bad_access = idle && ((bus.write && !w_ok) || (bus.read && !r_ok));

  // Index slices are only used when the matching range check passed.
  assign w_idx = bus.address_w[IDXW-1:0];
  assign r_idx = bus.address_r[IDXW-1:0];
  assign c_idx = cnt_q[IDXW-1:0];

  assign bus.busy = (state_q == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage has no reset; writes are suppressed while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem[c_idx] <= INIT_VALUE;
      end else if (do_write) begin
        mem[w_idx] <= bus.data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.addr_err   <= 1'b0;
    end else begin
      bus.data_valid <= do_read;
      bus.addr_err   <= bad_access;
      if (do_read) begin
        if (!r_ok) begin
          bus.data_out <= '0;
        end else if (hit) begin
          bus.data_out <= bus.data_in;
        end else begin
          bus.data_out <= mem[r_idx];
        end
      end
    end
  end

endmodule
